roulette_bet_engine: RTL and testbench

Parametrised, clocked successor to the even/odd roulette round logic. It supports three bet modes: parity, high/low and exact number. Stake size is variable, payouts per mode are configurable, balance saturates, and the block has explicit win/lose terminal states. It sits between the debounced KEY/SW inputs and the random-number generator, and drives the balance HEX decoder and the status LEDs.

---
 rtl/roulette_pkg.sv | 29 ++
 rtl/roulette_outcome.sv | 63 ++++++
 rtl/roulette_bet_engine.sv | 211 +++++++++++++++++++++
 tb/tb_roulette_bet_engine.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/roulette_pkg.sv
// Shared encodings for the roulette bet engine: FSM states, bet modes and
// game-over codes.
package roulette_pkg;

  // FSM state encoding, also driven out on the debug LEDs
  typedef enum logic [2:0] {
    READY = 3'd0,
    LATCH = 3'd1,
    EVAL  = 3'd2,
    WON   = 3'd3,
    LOST  = 3'd4
  } state_t;

  // Bet mode codes as presented on the mode switches
  typedef enum logic [1:0] {
    MODE_PARITY = 2'b00,
    MODE_HILO   = 2'b01,
    MODE_EXACT  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  // Game-over status codes
  typedef enum logic [1:0] {
    GO_PLAYING = 2'b00,
    GO_WON     = 2'b01,
    GO_LOST    = 2'b10
  } game_over_t;

endpackage

// File: rtl/roulette_outcome.sv
// Combinational round outcome: decides win/loss for the latched bet and
// computes the saturated balance that results from it.
module roulette_outcome
  import roulette_pkg::*;
#(
  parameter int NUM_W      = 6,
  parameter int MAX_NUM    = 36,
  parameter int BAL_W      = 8,
  parameter int BET_W      = 4,
  parameter int EXACT_MULT = 35
) (
  input  logic [1:0]       i_mode,
  input  logic [NUM_W-1:0] i_guess,
  input  logic [NUM_W-1:0] i_num,
  input  logic [BET_W-1:0] i_eff_bet,
  input  logic [BAL_W-1:0] i_balance,
  output logic             o_win,
  output logic [BAL_W-1:0] o_next_balance
);

  // Wide enough for balance plus the largest exact-number payout
  localparam int SUM_W = BAL_W + BET_W + 6;
  localparam logic [NUM_W-1:0] HALF    = NUM_W'(MAX_NUM / 2);
  localparam logic [SUM_W-1:0] BAL_MAX = {{(SUM_W - BAL_W){1'b0}}, {BAL_W{1'b1}}};

  logic             w_is_zero;
  logic             w_is_even;
  logic             w_is_high;
  logic             w_is_low;
  logic [SUM_W-1:0] w_bet_ext;
  logic [SUM_W-1:0] w_bal_ext;
  logic [SUM_W-1:0] w_gain;
  logic [SUM_W-1:0] w_sum;

  // Zero is neither even, high nor low, so it loses every even-money bet
  assign w_is_zero = (i_num == '0);
  assign w_is_even = ~i_num[0] & ~w_is_zero;
  assign w_is_high = (i_num > HALF);
  assign w_is_low  = ~w_is_zero & ~w_is_high;

  assign w_bet_ext = SUM_W'(i_eff_bet);
  assign w_bal_ext = SUM_W'(i_balance);
  assign w_gain    = (i_mode == MODE_EXACT) ? (w_bet_ext * SUM_W'(EXACT_MULT)) : w_bet_ext;

  // Decide whether the bet wins against the captured wheel number
  always_comb begin
    o_win = 1'b0;
    case (i_mode)
      MODE_PARITY: o_win = i_guess[0] ? w_is_even : i_num[0];
      MODE_HILO:   o_win = i_guess[0] ? w_is_high : w_is_low;
      MODE_EXACT:  o_win = (i_guess == i_num);
      default:     o_win = 1'b0;
    endcase
  end

  // Apply payout or stake loss; a loss never underflows because the stake
  // was clipped to the balance when it was latched
  always_comb begin
    w_sum = o_win ? (w_bal_ext + w_gain) : (w_bal_ext - w_bet_ext);
    o_next_balance = (w_sum > BAL_MAX) ? {BAL_W{1'b1}} : w_sum[BAL_W-1:0];
  end

endmodule

// File: rtl/roulette_bet_engine.sv
// Roulette round controller: spin edge detection, bet latching, wheel number
// capture with resampling of out-of-range values, balance bookkeeping and
// won/lost terminal states.
module roulette_bet_engine
  import roulette_pkg::*;
#(
  parameter int NUM_W      = 6,
  parameter int MAX_NUM    = 36,
  parameter int BAL_W      = 8,
  parameter int BET_W      = 4,
  parameter int START_BAL  = 10,
  parameter int WIN_BAL    = 20,
  parameter int EXACT_MULT = 35
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             spin,
  input  logic             new_game,
  input  logic [1:0]       mode,
  input  logic [NUM_W-1:0] guess,
  input  logic [BET_W-1:0] bet,
  input  logic [NUM_W-1:0] randnum,
  output logic [BAL_W-1:0] balance,
  output logic [2:0]       fsm_state,
  output logic             busy,
  output logic             round_done,
  output logic             win_led,
  output logic             lose_led,
  output logic             reject,
  output logic [1:0]       game_over
);

  // A starting balance that already wins makes the game meaningless
  if (START_BAL >= WIN_BAL) begin : g_bad_start_bal
    $error("roulette_bet_engine: START_BAL must be below WIN_BAL");
  end
  if (MAX_NUM >= (1 << NUM_W)) begin : g_bad_max_num
    $error("roulette_bet_engine: MAX_NUM does not fit in NUM_W bits");
  end
  if (EXACT_MULT >= 64) begin : g_bad_mult
    $error("roulette_bet_engine: EXACT_MULT exceeds the payout headroom");
  end

  localparam int CMP_W = (BAL_W > BET_W) ? BAL_W : BET_W;
  localparam logic [BAL_W-1:0] START_VAL = BAL_W'(START_BAL);
  localparam logic [BAL_W-1:0] WIN_VAL   = BAL_W'(WIN_BAL);
  localparam logic [NUM_W-1:0] MAX_VAL   = NUM_W'(MAX_NUM);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_spin_d;
  logic [1:0]       r_mode;
  logic [1:0]       w_mode_next;
  logic [NUM_W-1:0] r_guess;
  logic [NUM_W-1:0] w_guess_next;
  logic [NUM_W-1:0] r_num;
  logic [NUM_W-1:0] w_num_next;
  logic [BET_W-1:0] r_eff_bet;
  logic [BET_W-1:0] w_eff_bet_next;
  logic [BAL_W-1:0] r_balance;
  logic [BAL_W-1:0] w_balance_next;
  logic             r_win_led;
  logic             w_win_led_next;
  logic             r_lose_led;
  logic             w_lose_led_next;
  logic             r_round_done;
  logic             w_round_done_next;
  logic             r_reject;
  logic             w_reject_next;
  logic [1:0]       r_game_over;
  logic [1:0]       w_game_over_next;

  logic             w_spin_edge;
  logic             w_num_ok;
  logic [CMP_W-1:0] w_bal_cmp;
  logic [CMP_W-1:0] w_bet_cmp;
  logic [BET_W-1:0] w_eff_bet;
  logic             w_win;
  logic [BAL_W-1:0] w_outcome_bal;

  assign w_spin_edge = spin & ~r_spin_d;
  assign w_num_ok    = (randnum <= MAX_VAL);

  // Stake is clipped to what the player still holds
  assign w_bal_cmp = CMP_W'(r_balance);
  assign w_bet_cmp = CMP_W'(bet);
  assign w_eff_bet = (w_bal_cmp < w_bet_cmp) ? BET_W'(r_balance) : bet;

  roulette_outcome #(
    .NUM_W      (NUM_W),
    .MAX_NUM    (MAX_NUM),
    .BAL_W      (BAL_W),
    .BET_W      (BET_W),
    .EXACT_MULT (EXACT_MULT)
  ) u_outcome (
    .i_mode         (r_mode),
    .i_guess        (r_guess),
    .i_num          (r_num),
    .i_eff_bet      (r_eff_bet),
    .i_balance      (r_balance),
    .o_win          (w_win),
    .o_next_balance (w_outcome_bal)
  );

  // Next-state and datapath update for every FSM state
  always_comb begin
    w_state_next      = r_state;
    w_mode_next       = r_mode;
    w_guess_next      = r_guess;
    w_num_next        = r_num;
    w_eff_bet_next    = r_eff_bet;
    w_balance_next    = r_balance;
    w_win_led_next    = r_win_led;
    w_lose_led_next   = r_lose_led;
    w_round_done_next = 1'b0;
    w_reject_next     = 1'b0;
    w_game_over_next  = r_game_over;
    case (r_state)
      READY: begin
        if (new_game) begin
          w_balance_next  = START_VAL;
          w_win_led_next  = 1'b0;
          w_lose_led_next = 1'b0;
        end else if (w_spin_edge) begin
          if ((mode == MODE_RSVD) || (bet == '0)) begin
            w_reject_next = 1'b1;
          end else begin
            w_mode_next    = mode;
            w_guess_next   = guess;
            w_eff_bet_next = w_eff_bet;
            w_state_next   = LATCH;
          end
        end
      end
      LATCH: begin
        if (w_num_ok) begin
          w_num_next   = randnum;
          w_state_next = EVAL;
        end
      end
      EVAL: begin
        w_balance_next    = w_outcome_bal;
        w_win_led_next    = w_win;
        w_lose_led_next   = ~w_win;
        w_round_done_next = 1'b1;
        if (w_outcome_bal >= WIN_VAL) begin
          w_state_next     = WON;
          w_game_over_next = GO_WON;
        end else if (w_outcome_bal == '0) begin
          w_state_next     = LOST;
          w_game_over_next = GO_LOST;
        end else begin
          w_state_next = READY;
        end
      end
      WON, LOST: begin
        if (new_game) begin
          w_state_next     = READY;
          w_balance_next   = START_VAL;
          w_win_led_next   = 1'b0;
          w_lose_led_next  = 1'b0;
          w_game_over_next = GO_PLAYING;
        end
      end
      default: begin
        w_state_next = READY;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= READY;
      r_spin_d     <= 1'b0;
      r_mode       <= '0;
      r_guess      <= '0;
      r_num        <= '0;
      r_eff_bet    <= '0;
      r_balance    <= START_VAL;
      r_win_led    <= 1'b0;
      r_lose_led   <= 1'b0;
      r_round_done <= 1'b0;
      r_reject     <= 1'b0;
      r_game_over  <= GO_PLAYING;
    end else begin
      r_state      <= w_state_next;
      r_spin_d     <= spin;
      r_mode       <= w_mode_next;
      r_guess      <= w_guess_next;
      r_num        <= w_num_next;
      r_eff_bet    <= w_eff_bet_next;
      r_balance    <= w_balance_next;
      r_win_led    <= w_win_led_next;
      r_lose_led   <= w_lose_led_next;
      r_round_done <= w_round_done_next;
      r_reject     <= w_reject_next;
      r_game_over  <= w_game_over_next;
    end
  end

  assign balance    = r_balance;
  assign fsm_state  = r_state;
  assign busy       = (r_state == LATCH) || (r_state == EVAL);
  assign round_done = r_round_done;
  assign win_led    = r_win_led;
  assign lose_led   = r_lose_led;
  assign reject     = r_reject;
  assign game_over  = r_game_over;

endmodule

// File: tb/tb_roulette_bet_engine.sv
// Bench for roulette_bet_engine: directed scenarios followed by random rounds
// checked against a rule-level model of the game.
module tb_roulette_bet_engine;

  localparam int ST_READY = 0;
  localparam int ST_LATCH = 1;
  localparam int ST_EVAL  = 2;
  localparam int ST_WON   = 3;
  localparam int ST_LOST  = 4;
  localparam int HALF     = 18;
  localparam int BAL_MAX  = 255;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       spin;
  logic       new_game;
  logic [1:0] mode;
  logic [5:0] guess;
  logic [3:0] bet;
  logic [5:0] randnum;
  logic [7:0] balance;
  logic [2:0] fsm_state;
  logic       busy;
  logic       round_done;
  logic       win_led;
  logic       lose_led;
  logic       reject;
  logic [1:0] game_over;

  int compared   = 0;
  int mismatched = 0;

  // model state
  int bal = 10;
  int go  = 0;
  int wl  = 0;
  int ll  = 0;
  int rounds = 0;

  roulette_bet_engine dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .spin       (spin),
    .new_game   (new_game),
    .mode       (mode),
    .guess      (guess),
    .bet        (bet),
    .randnum    (randnum),
    .balance    (balance),
    .fsm_state  (fsm_state),
    .busy       (busy),
    .round_done (round_done),
    .win_led    (win_led),
    .lose_led   (lose_led),
    .reject     (reject),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // game rules stated directly
  function automatic bit model_win(input int m, input int g, input int n);
    if (m == 0) return (n != 0) && ((g % 2 == 1) ? (n % 2 == 0) : (n % 2 == 1));
    if (m == 1) return (n != 0) && ((g % 2 == 1) ? (n > HALF) : (n <= HALF));
    if (m == 2) return g == n;
    return 1'b0;
  endfunction

  task automatic scramble();
    mode     = 2'($urandom_range(0, 3));
    guess    = 6'($urandom_range(0, 63));
    bet      = 4'($urandom_range(0, 15));
    new_game = 1'($urandom_range(0, 1));
  endtask

  task automatic start_new_game();
    new_game = 1'b1;
    spin     = 1'b0;
    tick();
    chk("ng_balance", balance, 10);
    chk("ng_state", fsm_state, ST_READY);
    chk("ng_game_over", game_over, 0);
    chk("ng_win_led", win_led, 0);
    chk("ng_lose_led", lose_led, 0);
    new_game = 1'b0;
    bal = 10; go = 0; wl = 0; ll = 0;
    tick();
    $display("new game: balance=%0d", balance);
  endtask

  task automatic run_round(input int m, input int g, input int b, input int n, input int nbad);
    int eff;
    int exp_bal;
    bit w;
    rounds++;
    mode     = 2'(m);
    guess    = 6'(g);
    bet      = 4'(b);
    new_game = 1'b0;
    randnum  = (nbad > 0) ? 6'($urandom_range(37, 63)) : 6'(n);
    spin     = 1'b1;
    tick();
    if (go != 0) begin
      chk("over_reject", reject, 0);
      chk("over_state", fsm_state, (go == 1) ? ST_WON : ST_LOST);
      chk("over_balance", balance, bal);
      chk("over_game_over", game_over, go);
      spin = 1'b0;
      tick();
      $display("round %0d: mode=%0d guess=%0d bet=%0d ignored (game over %0d) balance=%0d",
               rounds, m, g, b, go, balance);
      return;
    end
    if (m == 3 || b == 0) begin
      chk("rej_pulse", reject, 1);
      chk("rej_state", fsm_state, ST_READY);
      chk("rej_balance", balance, bal);
      chk("rej_win_led", win_led, wl);
      spin = 1'b0;
      tick();
      chk("rej_pulse_end", reject, 0);
      $display("round %0d: mode=%0d bet=%0d rejected balance=%0d", rounds, m, b, balance);
      return;
    end
    eff = (b < bal) ? b : bal;
    chk("latch_state", fsm_state, ST_LATCH);
    chk("latch_busy", busy, 1);
    for (int i = 0; i < nbad; i++) begin
      scramble();
      tick();
      chk("resample_state", fsm_state, ST_LATCH);
      randnum = (i == nbad - 1) ? 6'(n) : 6'($urandom_range(37, 63));
    end
    scramble();
    tick();
    chk("eval_state", fsm_state, ST_EVAL);
    chk("eval_busy", busy, 1);
    randnum = 6'($urandom_range(0, 63));
    scramble();
    w = model_win(m, g, n);
    exp_bal = w ? bal + eff * ((m == 2) ? 35 : 1) : bal - eff;
    if (exp_bal > BAL_MAX) exp_bal = BAL_MAX;
    tick();
    bal = exp_bal;
    wl  = w;
    ll  = !w;
    go  = (bal >= 20) ? 1 : ((bal == 0) ? 2 : 0);
    chk("done_balance", balance, bal);
    chk("done_win_led", win_led, wl);
    chk("done_lose_led", lose_led, ll);
    chk("done_pulse", round_done, 1);
    chk("done_busy", busy, 0);
    chk("done_game_over", game_over, go);
    chk("done_state", fsm_state, (go == 1) ? ST_WON : ((go == 2) ? ST_LOST : ST_READY));
    spin     = 1'b0;
    new_game = 1'b0;
    tick();
    chk("done_pulse_end", round_done, 0);
    chk("done_balance_hold", balance, bal);
    $display("round %0d: mode=%0d guess=%0d bet=%0d eff=%0d num=%0d bad=%0d win=%0d balance=%0d game_over=%0d",
             rounds, m, g, b, eff, n, nbad, w, balance, game_over);
  endtask

  initial begin
    int cnt;
    int m;
    int g;
    int n;
    reset_n  = 1'b0;
    spin     = 1'b0;
    new_game = 1'b0;
    mode     = 2'd0;
    guess    = 6'd0;
    bet      = 4'd0;
    randnum  = 6'd0;
    tick();
    tick();
    chk("rst_balance", balance, 10);
    chk("rst_state", fsm_state, ST_READY);
    chk("rst_busy", busy, 0);
    chk("rst_round_done", round_done, 0);
    chk("rst_win_led", win_led, 0);
    chk("rst_lose_led", lose_led, 0);
    chk("rst_reject", reject, 0);
    chk("rst_game_over", game_over, 0);
    reset_n = 1'b1;
    tick();

    // held spin triggers exactly one round
    mode = 2'd0; guess = 6'd1; bet = 4'd2; randnum = 6'd14; spin = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (round_done === 1'b1) cnt++;
      if (i == 3) chk("held_done_k3", round_done, 1);
    end
    chk("held_pulses", cnt, 1);
    chk("held_balance", balance, 12);
    chk("held_win_led", win_led, 1);
    spin = 1'b0;
    tick();
    $display("held spin round: balance=%0d pulses=%0d", balance, cnt);

    // reset in the middle of a round
    spin = 1'b1;
    tick();
    tick();
    chk("midrst_in_eval", fsm_state, ST_EVAL);
    reset_n = 1'b0;
    spin    = 1'b0;
    tick();
    chk("midrst_balance", balance, 10);
    chk("midrst_state", fsm_state, ST_READY);
    chk("midrst_win_led", win_led, 0);
    chk("midrst_lose_led", lose_led, 0);
    chk("midrst_game_over", game_over, 0);
    reset_n = 1'b1;
    bal = 10; go = 0; wl = 0; ll = 0;
    tick();
    $display("mid-round reset: balance=%0d", balance);

    // high/low loss on zero, then reserved mode rejected
    run_round(1, 1, 3, 0, 0);
    run_round(3, 1, 3, 5, 0);
    chk("after_rej_balance", balance, 7);

    // exact win reaches the won state
    start_new_game();
    run_round(2, 7, 1, 7, 0);
    chk("exact_balance", balance, 45);
    run_round(0, 1, 2, 14, 0);
    start_new_game();

    // losing down to zero with a clipped stake
    run_round(0, 1, 8, 0, 0);
    run_round(0, 1, 5, 9, 0);
    chk("lost_game_over", game_over, 2);
    run_round(1, 0, 4, 3, 0);
    start_new_game();

    // payout saturates at the balance ceiling
    run_round(2, 5, 15, 5, 0);
    chk("sat_balance", balance, 255);
    start_new_game();

    // new_game wins over a simultaneous spin; then resampling out-of-range numbers
    run_round(0, 1, 2, 14, 0);
    mode = 2'd0; guess = 6'd0; bet = 4'd3; randnum = 6'd40;
    spin = 1'b1; new_game = 1'b1;
    tick();
    chk("prio_state", fsm_state, ST_READY);
    chk("prio_balance", balance, 10);
    chk("prio_busy", busy, 0);
    spin = 1'b0; new_game = 1'b0;
    bal = 10; wl = 0; ll = 0;
    tick();
    spin = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (busy === 1'b1) cnt++;
      if (i == 4) randnum = 6'd9;
    end
    chk("resample_busy_cycles", cnt, 5);
    chk("resample_balance", balance, 13);
    chk("resample_win_led", win_led, 1);
    spin = 1'b0;
    bal = 13; wl = 1; ll = 0;
    tick();
    $display("resample round: busy=%0d balance=%0d", cnt, balance);

    // random rounds
    for (int r = 0; r < 80; r++) begin
      if (go != 0) begin
        if ($urandom_range(0, 1) == 1) run_round(0, 1, 1, 2, 0);
        start_new_game();
      end else if ($urandom_range(0, 9) == 0) begin
        start_new_game();
      end
      m = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      n = $urandom_range(0, 36);
      g = (m == 2 && $urandom_range(0, 1) == 1) ? n : int'($urandom_range(0, 63));
      run_round(m, g, $urandom_range(0, 15), n, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
